// File: rtl/alu_exec_unit_if.sv
// Request/response bundle between the decode stage and alu_exec_unit.
// The master drives operands and decoded fields; the slave returns the result and status.
interface alu_exec_unit_if #(
  parameter int unsigned XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [1:0]      ALUOp;
  logic [2:0]      funct3;
  logic            funct7b5;
  logic            funct7b0;
  logic            opb5;
  logic [XLEN-1:0] SrcA;
  logic [XLEN-1:0] SrcB;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] ALUResult;
  logic            Zero;
  logic            busy;

  modport master (
    output in_valid, ALUOp, funct3, funct7b5, funct7b0, opb5, SrcA, SrcB, out_ready,
    input  in_ready, out_valid, ALUResult, Zero, busy
  );

  modport slave (
    input  in_valid, ALUOp, funct3, funct7b5, funct7b0, opb5, SrcA, SrcB, out_ready,
    output in_ready, out_valid, ALUResult, Zero, busy
  );
endinterface

// File: rtl/alu_exec_unit.sv
// Registered ALU-control decode plus XLEN-bit ALU behind a valid/ready handshake.
// Define ALU_MULDIV_EN to add the iterative RV32M/RV64M multiply/divide engine.
module alu_exec_unit #(
  parameter int unsigned XLEN = 32
) (
  input  logic           clk,
  input  logic           reset,
  alu_exec_unit_if.slave bus
);
  localparam int unsigned SW = $clog2(XLEN);

  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND
  } op_e;

`ifdef ALU_MULDIV_EN
  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;
`else
  typedef enum logic {S_IDLE, S_DONE} state_e;
`endif

  state_e          state_q;
  logic [XLEN-1:0] res_q;
  op_e             op_d;
  logic [XLEN-1:0] alu_d;
  logic [SW-1:0]   shamt;
  logic            accept;

  assign bus.in_ready  = (state_q == S_IDLE) | ((state_q == S_DONE) & bus.out_ready);
  assign accept        = bus.in_valid & bus.in_ready;
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.ALUResult = res_q;
  assign bus.Zero      = (res_q == '0);
  assign shamt         = bus.SrcB[SW-1:0];

  always_comb begin
    op_d = OP_ADD;
    case (bus.ALUOp)
      2'b01: op_d = OP_SUB;
      2'b10: begin
        case (bus.funct3)
          3'b000:  op_d = (bus.funct7b5 & bus.opb5) ? OP_SUB : OP_ADD;
          3'b001:  op_d = OP_SLL;
          3'b010:  op_d = OP_SLT;
          3'b011:  op_d = OP_SLTU;
          3'b100:  op_d = OP_XOR;
          3'b101:  op_d = bus.funct7b5 ? OP_SRA : OP_SRL;
          3'b110:  op_d = OP_OR;
          default: op_d = OP_AND;
        endcase
      end
      default: op_d = OP_ADD;
    endcase
  end

  always_comb begin
    alu_d = '0;
    case (op_d)
      OP_ADD:  alu_d = bus.SrcA + bus.SrcB;
      OP_SUB:  alu_d = bus.SrcA - bus.SrcB;
      OP_SLL:  alu_d = bus.SrcA << shamt;
      OP_SLT:  alu_d = {{(XLEN-1){1'b0}}, ($signed(bus.SrcA) < $signed(bus.SrcB))};
      OP_SLTU: alu_d = {{(XLEN-1){1'b0}}, (bus.SrcA < bus.SrcB)};
      OP_XOR:  alu_d = bus.SrcA ^ bus.SrcB;
      OP_SRL:  alu_d = bus.SrcA >> shamt;
      OP_SRA:  alu_d = $unsigned($signed(bus.SrcA) >>> shamt);
      OP_OR:   alu_d = bus.SrcA | bus.SrcB;
      OP_AND:  alu_d = bus.SrcA & bus.SrcB;
      default: alu_d = '0;
    endcase
  end

`ifdef ALU_MULDIV_EN
  localparam int unsigned CW = $clog2(XLEN) + 1;

  logic [CW-1:0]     cnt_q;
  logic [2:0]        mf3_q;
  logic [XLEN-1:0]   hi_q, lo_q, mcand_q, a_q;
  logic              negq_q, negr_q, div0_q;
  logic              md_sel, a_sgn, b_sgn;
  logic [XLEN-1:0]   ma_d, mb_d, hi_d, lo_d, fin_d, quo_s, rem_s;
  logic [XLEN:0]     psum, rsh;
  logic [XLEN+1:0]   rdiff;
  logic [2*XLEN-1:0] prod_s;

  assign md_sel   = (bus.ALUOp == 2'b10) & bus.opb5 & bus.funct7b0;
  assign bus.busy = (state_q == S_BUSY);

  // Which operands are treated as signed: mulh/div/rem both, mulhsu only A.
  always_comb begin
    a_sgn = 1'b0;
    b_sgn = 1'b0;
    case (bus.funct3)
      3'b001, 3'b100, 3'b110: begin
        a_sgn = bus.SrcA[XLEN-1];
        b_sgn = bus.SrcB[XLEN-1];
      end
      3'b010:  a_sgn = bus.SrcA[XLEN-1];
      default: ;
    endcase
  end

  assign ma_d = a_sgn ? -bus.SrcA : bus.SrcA;
  assign mb_d = b_sgn ? -bus.SrcB : bus.SrcB;

  // hi:lo is the product accumulator for multiply, remainder:quotient for divide.
  always_comb begin
    psum  = {1'b0, hi_q} + {1'b0, (mcand_q & {XLEN{lo_q[0]}})};
    rsh   = {hi_q, lo_q[XLEN-1]};
    rdiff = {1'b0, rsh} - {2'b00, mcand_q};
    if (!mf3_q[2]) begin
      hi_d = psum[XLEN:1];
      lo_d = {psum[0], lo_q[XLEN-1:1]};
    end else if (!rdiff[XLEN+1]) begin
      hi_d = rdiff[XLEN-1:0];
      lo_d = {lo_q[XLEN-2:0], 1'b1};
    end else begin
      hi_d = rsh[XLEN-1:0];
      lo_d = {lo_q[XLEN-2:0], 1'b0};
    end
  end

  // Signed overflow needs no special case: |min|/1 = min with no negation, remainder 0.
  always_comb begin
    prod_s = negq_q ? -{hi_q, lo_q} : {hi_q, lo_q};
    quo_s  = div0_q ? '1  : (negq_q ? -lo_q : lo_q);
    rem_s  = div0_q ? a_q : (negr_q ? -hi_q : hi_q);
    case (mf3_q)
      3'b000:                 fin_d = prod_s[XLEN-1:0];
      3'b001, 3'b010, 3'b011: fin_d = prod_s[2*XLEN-1:XLEN];
      3'b100, 3'b101:         fin_d = quo_s;
      default:                fin_d = rem_s;
    endcase
  end
`else
  logic unused_f7b0;
  assign unused_f7b0 = bus.funct7b0;
  assign bus.busy    = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      res_q   <= '0;
`ifdef ALU_MULDIV_EN
      cnt_q   <= '0;
      mf3_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      mcand_q <= '0;
      a_q     <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      div0_q  <= 1'b0;
`endif
    end else begin
      case (state_q)
`ifdef ALU_MULDIV_EN
        S_BUSY: begin
          if (cnt_q == CW'(XLEN)) begin
            state_q <= S_DONE;
            res_q   <= fin_d;
            cnt_q   <= '0;
          end else begin
            hi_q  <= hi_d;
            lo_q  <= lo_d;
            cnt_q <= cnt_q + 1'b1;
          end
        end
`endif
        default: begin
          if (accept) begin
`ifdef ALU_MULDIV_EN
            if (md_sel) begin
              state_q <= S_BUSY;
              mf3_q   <= bus.funct3;
              hi_q    <= '0;
              lo_q    <= ma_d;
              mcand_q <= mb_d;
              a_q     <= bus.SrcA;
              negq_q  <= a_sgn ^ b_sgn;
              negr_q  <= a_sgn;
              div0_q  <= (bus.SrcB == '0);
              cnt_q   <= '0;
            end else
`endif
            begin
              state_q <= S_DONE;
              res_q   <= alu_d;
            end
          end else if ((state_q == S_DONE) && bus.out_ready) begin
            state_q <= S_IDLE;
          end
        end
      endcase
    end
  end
endmodule

// File: doc/alu_exec_unit.md
# alu_exec_unit

Parametrised, handshaked execute unit that merges ALU-control decoding and the ALU datapath into one registered stage for the next core generation. It takes the main decoder's 2-bit ALUOp plus instruction fields, computes the result on an XLEN-bit datapath, and returns it over a valid/ready handshake. Single-cycle integer ops complete in one cycle. An optional iterative RV32M/RV64M multiply/divide engine stalls the pipeline through the same handshake.

## Interface
- XLEN, 32, datapath width (32 or 64); shift amount is SrcB[$clog2(XLEN)-1:0]
- clk  in  1  system clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- in_valid  in  1  operands/fields valid this cycle
- in_ready  out  1  unit can accept; transfer when in_valid & in_ready
- ALUOp  in  2  00 add, 01 sub, 10 decode by funct3/funct7, 11 reserved (add)
- funct3  in  3  instruction funct3
- funct7b5  in  1  instruction bit 30
- funct7b0  in  1  instruction bit 25 (M-extension select)
- opb5  in  1  opcode bit 5 (1 = R-type)
- SrcA, SrcB  in  XLEN  operands
- out_valid  out  1  ALUResult valid
- out_ready  in  1  consumer accepts; transfer when out_valid & out_ready
- ALUResult  out  XLEN  registered result
- Zero  out  1  (ALUResult == 0), combinational from the result register
- busy  out  1  multi-cycle op in progress

## Operation
- Internal 4-bit op code, decoded at acceptance for ALUOp=10:
  - funct3 000: sub if funct7b5 & opb5, else add.
  - 001: sll.
  - 010: slt (signed).
  - 011: sltu (unsigned).
  - 100: xor.
  - 101: sra if funct7b5, else srl (applies to I-type too).
  - 110: or.
  - 111: and.
- Add/sub wrap modulo 2^XLEN. slt/sltu produce 0 or 1, zero-extended.
- FSM states:
  - IDLE: accepting.
  - BUSY: iterating mul/div.
  - DONE: out_valid=1, holding result.
- Transitions:
  - IDLE --accept single-cycle op--> DONE.
  - IDLE --accept mul/div--> BUSY.
  - BUSY --counter reaches XLEN--> DONE.
  - DONE --out_ready & !accept--> IDLE.
  - DONE --out_ready & accept--> DONE or BUSY, depending on the new op (back-to-back).
- in_ready = (state==IDLE) | (state==DONE & out_ready). It is never asserted in BUSY.
- ALUResult, out_valid and Zero stay stable while out_valid & !out_ready.
- Reset values: state IDLE, out_valid 0, busy 0, ALUResult 0, Zero 1, iteration counter 0. Reset mid-BUSY aborts the operation; no result is produced.

## Timing
- Single-cycle op accepted at edge k: out_valid=1 after edge k, i.e. result visible in cycle k+1. Throughput is one op per cycle with out_ready held at 1.
- Mul/div accepted at edge k: busy=1 from k+1. out_valid=1 after edge k+XLEN+1, i.e. XLEN iteration cycles plus one finalise cycle. busy drops when out_valid rises.
- Operands and decoded op are captured at acceptance. Later input changes have no effect.

## Configuration
- Macro ALU_MULDIV_EN.
- Defined:
  - ALUOp=10 & opb5 & funct7b0 selects M ops by funct3: 000 mul, 001 mulh, 010 mulhsu, 011 mulhu, 100 div, 101 divu, 110 rem, 111 remu.
  - Multiply is shift-add; divide is restoring, on magnitudes with sign fix-up in the finalise cycle.
  - Divide by zero: quotient all ones, remainder = SrcA.
  - Signed overflow (-2^(XLEN-1) / -1): quotient = SrcA, remainder 0.
- Not defined:
  - funct7b0 is ignored and no BUSY state or multiply/divide datapath is synthesised.
  - busy is tied 0. Every op completes in one cycle.

## Test plan
- Reset then R-type sub: reset pulsed mid-cycle asynchronously gives out_valid=0, ALUResult=0, Zero=1. Then ALUOp=10, funct3=000, funct7b5=1, opb5=1, SrcA=5, SrcB=7 gives ALUResult=0xFFFFFFFE one cycle after acceptance, Zero=0.
- I-type/shift decode: addi with funct7b5=1, opb5=0, 3+4 gives 7. srai of 0x80000000 by 4 gives 0xF8000000. srl of the same gives 0x08000000. sltu 1 vs 0xFFFFFFFF gives 1. slt 1 vs 0xFFFFFFFF gives 0.
- Back-to-back with backpressure: 3 adds streamed with out_ready=1 produce one result per cycle. Dropping out_ready for 2 cycles holds ALUResult stable and deasserts in_ready.
- (ALU_MULDIV_EN) mul 0xFFFFFFFF × 0xFFFFFFFF gives low 1 and mulhu 0xFFFFFFFE, each after 33 cycles. div 7/0 gives 0xFFFFFFFF. rem 7/0 gives 7. div 0x80000000 / -1 gives 0x80000000.
- (ALU_MULDIV_EN) reset asserted 10 cycles into a divu: busy=0 and out_valid=0 immediately. A following add completes in 1 cycle with the correct result.
